// File: rtl/p09_debounce_pkg.sv
// Shared types and width helpers for the debounced input conditioner and its
// round-robin event arbiter.
package p09_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } db_state_t;

  // Channel field is sized for the largest supported NUM_CH (256); users truncate.
  localparam int EVT_CH_MAX_W = 8;

  typedef struct packed {
    logic [EVT_CH_MAX_W-1:0] channel;
    logic                    rise;
  } evt_t;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/p09_debounce_arbiter_if.sv
// Valid/ready event port: the arbiter drives channel/polarity, the consumer drives ready.
interface p09_debounce_arbiter_if #(
  parameter int CH_W = 2
);
  logic            evt_valid;
  logic            evt_ready;
  logic [CH_W-1:0] evt_channel;
  logic            evt_rise;

  modport master (output evt_valid, output evt_channel, output evt_rise, input evt_ready);
  modport slave  (input evt_valid, input evt_channel, input evt_rise, output evt_ready);
endinterface

// File: rtl/p09_debounce_channel.sv
// One input channel: synchronizer chain followed by a debounce FSM that emits a
// single-cycle strobe on the edge where a new level is accepted.
module p09_debounce_channel
  import p09_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_evt,
  output logic o_rise
);
  localparam int               CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  db_state_t              r_state;
  db_state_t              w_state_next;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_count_next;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= '0;
      r_state <= STABLE_LOW;
      r_count <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      STABLE_LOW: if (w_sync) begin
        w_state_next = WAIT_HIGH;
        w_count_next = '0;
      end
      STABLE_HIGH: if (!w_sync) begin
        w_state_next = WAIT_LOW;
        w_count_next = '0;
      end
      // A reversal while waiting is a glitch: fall back without touching the level.
      WAIT_HIGH: begin
        if (!w_sync)             w_state_next = STABLE_LOW;
        else if (r_count == LAST) w_state_next = STABLE_HIGH;
        else                     w_count_next = r_count + CNT_W'(1);
      end
      WAIT_LOW: begin
        if (w_sync)              w_state_next = STABLE_HIGH;
        else if (r_count == LAST) w_state_next = STABLE_LOW;
        else                     w_count_next = r_count + CNT_W'(1);
      end
      default: w_state_next = STABLE_LOW;
    endcase
  end

  always_comb begin
    o_level = (r_state == STABLE_HIGH) || (r_state == WAIT_LOW);
    o_evt   = (r_count == LAST) &&
              (((r_state == WAIT_HIGH) && w_sync) || ((r_state == WAIT_LOW) && !w_sync));
    o_rise  = (r_state == WAIT_HIGH);
  end

endmodule

// File: rtl/p09_debounce_arbiter.sv
// NUM_CH debounced inputs whose confirmed edges sit in one-deep pending slots and
// are served round-robin through a registered valid/ready event port.
module p09_debounce_arbiter
  import p09_debounce_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     in,
  output logic [NUM_CH-1:0]     level,
  output logic [NUM_CH-1:0]     overflow,
  input  logic [NUM_CH-1:0]     overflow_clr,
  p09_debounce_arbiter_if.master evt
);
  localparam int CH_W = idx_width(NUM_CH);

  logic [NUM_CH-1:0] w_ch_evt, w_ch_rise, w_grant;
  logic [NUM_CH-1:0] r_slot_valid, r_slot_rise, r_overflow;
  logic [NUM_CH-1:0] w_slot_valid_next, w_slot_rise_next, w_overflow_next;
  logic [CH_W-1:0]   r_ptr, w_grant_idx;
  logic              w_found, w_grant_rise, w_load, r_evt_valid;
  evt_t              r_evt;
  int                w_dist, w_best;

  assign w_load = !r_evt_valid || evt.evt_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      p09_debounce_channel #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
        .clk    (clk),
        .reset  (reset),
        .i_pin  (in[gi]),
        .o_level(level[gi]),
        .o_evt  (w_ch_evt[gi]),
        .o_rise (w_ch_rise[gi])
      );

      assign w_grant[gi] = w_load && w_found && (w_grant_idx == CH_W'(gi));
      // A new event always wins the slot; it only counts as lost data if the old one stays ungranted.
      assign w_slot_valid_next[gi] = w_ch_evt[gi] || (r_slot_valid[gi] && !w_grant[gi]);
      assign w_slot_rise_next[gi]  = w_ch_evt[gi] ? w_ch_rise[gi] : r_slot_rise[gi];
      assign w_overflow_next[gi]   = !overflow_clr[gi] &&
          (r_overflow[gi] || (w_ch_evt[gi] && r_slot_valid[gi] && !w_grant[gi]));
    end
  endgenerate

  // Pick the valid slot with the smallest rotational distance from the pointer.
  always_comb begin
    w_found      = 1'b0;
    w_grant_idx  = '0;
    w_grant_rise = 1'b0;
    w_best       = NUM_CH;
    w_dist       = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_dist = c - int'(r_ptr);
      if (w_dist < 0) w_dist = w_dist + NUM_CH;
      if (r_slot_valid[c] && (w_dist < w_best)) begin
        w_best       = w_dist;
        w_found      = 1'b1;
        w_grant_idx  = CH_W'(c);
        w_grant_rise = r_slot_rise[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_valid <= '0;
      r_slot_rise  <= '0;
      r_overflow   <= '0;
      r_ptr        <= '0;
      r_evt_valid  <= 1'b0;
      r_evt        <= '0;
    end else begin
      r_slot_valid <= w_slot_valid_next;
      r_slot_rise  <= w_slot_rise_next;
      r_overflow   <= w_overflow_next;
      if (w_load) begin
        r_evt_valid <= w_found;
        if (w_found) begin
          r_evt.channel <= EVT_CH_MAX_W'(w_grant_idx);
          r_evt.rise    <= w_grant_rise;
          r_ptr         <= (w_grant_idx == CH_W'(NUM_CH - 1)) ? '0 : w_grant_idx + CH_W'(1);
        end
      end
    end
  end

  assign evt.evt_valid   = r_evt_valid;
  assign evt.evt_channel = CH_W'(r_evt.channel);
  assign evt.evt_rise    = r_evt.rise;
  assign overflow        = r_overflow;

endmodule

// File: tb/tb_p09_debounce_arbiter.sv
// Scoreboard bench: a debounce/arbitration reference model predicts events and flags,
// a negedge monitor compares the DUT against it; a 1-channel instance covers the edge case.
module tb_p09_debounce_arbiter;
  localparam int N = 4;
  localparam int S = 2;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] in_a, level_a, ovf_a, clr_a;
  logic [0:0] in_b, level_b, ovf_b, clr_b;

  p09_debounce_arbiter_if #(.CH_W(2)) if_a ();
  p09_debounce_arbiter_if #(.CH_W(1)) if_b ();

  p09_debounce_arbiter #(.NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset), .in(in_a), .level(level_a),
    .overflow(ovf_a), .overflow_clr(clr_a), .evt(if_a.master));

  p09_debounce_arbiter #(.NUM_CH(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset), .in(in_b), .level(level_b),
    .overflow(ovf_b), .overflow_clr(clr_b), .evt(if_b.master));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (dut_a) ----------------
  typedef struct { int ch; bit rise; } exp_t;
  exp_t     exp_q[$];
  bit [3:0] hist[$];
  bit [3:0] m_level, m_slot_v, m_slot_r, m_ov;
  int       run[4];
  int       m_ptr;
  bit       m_valid;

  task automatic model_reset();
    hist.delete();
    repeat (S) hist.push_back(4'b0);
    m_level = '0; m_slot_v = '0; m_slot_r = '0; m_ov = '0;
    for (int i = 0; i < N; i++) run[i] = 0;
    m_ptr = 0; m_valid = 1'b0;
    exp_q.delete();
  endtask

  // Level accepted once the synchronized pin has differed from it for D+1 consecutive samples.
  task automatic model_step();
    bit [3:0] s, new_evt, new_rise;
    int       gnt;
    if (reset) begin
      model_reset();
      return;
    end
    s = hist.pop_front();
    hist.push_back(in_a);
    new_evt = '0; new_rise = '0;
    for (int c = 0; c < N; c++) begin
      if (s[c] != m_level[c]) begin
        run[c]++;
        if (run[c] == D + 1) begin
          m_level[c] = s[c]; run[c] = 0; new_evt[c] = 1'b1; new_rise[c] = s[c];
        end
      end else run[c] = 0;
    end
    gnt = -1;
    if (!m_valid || if_a.evt_ready) begin
      for (int k = 0; k < N; k++)
        if (gnt < 0 && m_slot_v[(m_ptr + k) % N]) gnt = (m_ptr + k) % N;
      m_valid = (gnt >= 0);
      if (gnt >= 0) begin
        exp_q.push_back('{ch: gnt, rise: m_slot_r[gnt]});
        m_ptr = (gnt + 1) % N;
      end
    end
    for (int c = 0; c < N; c++) begin
      bit set_ov;
      set_ov = new_evt[c] && m_slot_v[c] && (c != gnt);
      if (new_evt[c]) begin
        m_slot_v[c] = 1'b1; m_slot_r[c] = new_rise[c];
      end else if (c == gnt) m_slot_v[c] = 1'b0;
      m_ov[c] = clr_a[c] ? 1'b0 : (m_ov[c] | set_ov);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (!reset) begin
        check("evt_valid", if_a.evt_valid, m_valid);
        check("level", level_a, m_level);
        check("overflow", ovf_a, m_ov);
        if (if_a.evt_valid && if_a.evt_ready) begin
          $display("evt ch=%0d rise=%0d", if_a.evt_channel, if_a.evt_rise);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL evt_unexpected: got ch=%0d rise=%0d want none", if_a.evt_channel, if_a.evt_rise);
          end else begin
            e = exp_q.pop_front();
            check("evt_channel", if_a.evt_channel, e.ch);
            check("evt_rise", if_a.evt_rise, e.rise);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; in_a = '0; clr_a = '0; in_b = '0; clr_b = '0;
    if_a.evt_ready = 1'b0; if_b.evt_ready = 1'b1;
    tick(3);
    check("rst_level", level_a, 0);
    check("rst_valid", if_a.evt_valid, 0);
    check("rst_channel", if_a.evt_channel, 0);
    check("rst_rise", if_a.evt_rise, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_valid_b", if_b.evt_valid, 0);

    // Latency: pin sampled at edge 0, level after edge 6, event after edge 7.
    reset = 1'b0; if_a.evt_ready = 1'b1; in_a[1] = 1'b1;
    tick(7);
    check("lat_level", level_a[1], 1);
    check("lat_valid_early", if_a.evt_valid, 0);
    tick(1);
    check("lat_valid", if_a.evt_valid, 1);
    check("lat_channel", if_a.evt_channel, 1);
    check("lat_rise", if_a.evt_rise, 1);
    tick(1);
    check("lat_drained", if_a.evt_valid, 0);

    // Glitch shorter than the debounce window, then a held level.
    in_a[0] = 1'b1; tick(3); in_a[0] = 1'b0; tick(10);
    check("glitch_level", level_a[0], 0);
    check("glitch_valid", if_a.evt_valid, 0);
    check("glitch_ovf", ovf_a, 0);
    in_a[0] = 1'b1; tick(10);
    check("held_level", level_a[0], 1);

    // Simultaneous rises served in round-robin order from pointer 0.
    in_a = '0; tick(15);
    reset = 1'b1; tick(1); reset = 1'b0;
    in_a = 4'b1101; tick(8);
    check("rr1_ch_a", if_a.evt_channel, 0);
    tick(1); check("rr1_ch_b", if_a.evt_channel, 2);
    tick(1); check("rr1_ch_c", if_a.evt_channel, 3);
    tick(1); check("rr1_idle", if_a.evt_valid, 0);
    in_a = 4'b0100; tick(8);
    check("rr2_ch_a", if_a.evt_channel, 0);
    check("rr2_rise_a", if_a.evt_rise, 0);
    tick(1); check("rr2_ch_b", if_a.evt_channel, 3);

    // Back-pressure, slot overwrite and overflow clear behaviour.
    tick(2);
    if_a.evt_ready = 1'b0; in_a[1] = 1'b1; tick(8);
    check("bp_valid", if_a.evt_valid, 1);
    check("bp_channel", if_a.evt_channel, 1);
    in_a[1] = 1'b0; tick(8);
    check("bp_hold_rise", if_a.evt_rise, 1);
    check("bp_no_ovf", ovf_a[1], 0);
    in_a[1] = 1'b1; tick(8);
    check("bp_ovf_set", ovf_a[1], 1);
    clr_a[1] = 1'b1; tick(1); clr_a = '0;
    check("bp_ovf_clr", ovf_a[1], 0);
    in_a[1] = 1'b0; tick(6);
    clr_a[1] = 1'b1; tick(1); clr_a = '0;
    check("clr_vs_set_level", level_a[1], 0);
    check("clr_vs_set_ovf", ovf_a[1], 0);
    if_a.evt_ready = 1'b1; tick(4);

    // Reset while an event is presented and slots are pending.
    if_a.evt_ready = 1'b0; in_a = 4'b1011; tick(9);
    check("mid_valid", if_a.evt_valid, 1);
    reset = 1'b1; tick(1); reset = 1'b0;
    check("mid_rst_valid", if_a.evt_valid, 0);
    check("mid_rst_level", level_a, 0);
    in_a = 4'b1111; if_a.evt_ready = 1'b1; tick(7);
    check("mid_relevel", level_a, 4'hf);
    check("mid_revalid_early", if_a.evt_valid, 0);
    tick(1);
    check("mid_revalid", if_a.evt_valid, 1);
    check("mid_rech", if_a.evt_channel, 0);
    tick(6);

    // Single channel, one-cycle debounce window.
    in_b = 1'b1; tick(1); in_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("b_glitch_level", level_b, 0);
      check("b_glitch_valid", if_b.evt_valid, 0);
    end
    in_b = 1'b1; tick(2); in_b = 1'b0; tick(2);
    check("b_level_hi", level_b, 1);
    tick(1);
    check("b_rise_valid", if_b.evt_valid, 1);
    check("b_rise", if_b.evt_rise, 1);
    check("b_channel", if_b.evt_channel, 0);
    tick(1);
    check("b_level_lo", level_b, 0);
    check("b_gap", if_b.evt_valid, 0);
    tick(1);
    check("b_fall_valid", if_b.evt_valid, 1);
    check("b_fall", if_b.evt_rise, 0);
    check("b_ovf", ovf_b, 0);

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(11) == 0) in_a[c] = ~in_a[c];
        clr_a[c] = ($urandom_range(39) == 0);
      end
      if_a.evt_ready = ($urandom_range(3) != 0);
      tick(1);
    end
    clr_a = '0; if_a.evt_ready = 1'b1; tick(40);
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", if_a.evt_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p09_debounce_arbiter.md
Name: p09_debounce_arbiter

Overview:
Conditions NUM_CH asynchronous inputs (buttons, switches, external strobes) for the core clock domain. Each channel is synchronized, then debounced by a per-channel state machine. Confirmed rising and falling edges are queued as events and served round-robin over one valid/ready event port. Sits between top-level pads and the control logic that consumes user input.

Parameters:
NUM_CH, 4, number of input channels (>=1)
SYNC_STAGES, 2, synchronizer flip-flop depth per channel (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a level change (>=1)

Ports:
clk  in  1  single system clock
reset  in  1  synchronous, active-high reset
in  in  NUM_CH  raw asynchronous inputs
level  out  NUM_CH  debounced level per channel
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event when evt_valid & evt_ready at clk edge
evt_channel  out  max(1,$clog2(NUM_CH))  channel index of the presented event
evt_rise  out  1  1 = rising edge, 0 = falling edge
overflow  out  NUM_CH  sticky flag: an event was overwritten before being granted
overflow_clr  in  NUM_CH  per-bit clear of overflow; clear has priority over set in the same cycle

Behaviour:
- Reset (sampled at clk edge with reset=1): sync flops 0, all channels STABLE_LOW, level=0, pending slots empty, evt_valid=0, evt_channel=0, evt_rise=0, overflow=0, round-robin pointer=0. Reset mid-operation drops any presented or pending event.
- An input that is high at reset release produces a normal rising event after full latency.
- Synchronizer: shift chain of SYNC_STAGES flops; sync_out = last stage. Pin value sampled at edge 0 appears on sync_out after edge SYNC_STAGES-1.
- Debounce FSM per channel, states STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW:
  - STABLE_x with sync_out != x -> WAIT_(!x), count=0.
  - WAIT_y with sync_out != y -> back to STABLE_(!y). This is a glitch: no event, level unchanged.
  - WAIT_y with sync_out == y and count == DEBOUNCE_CYCLES-1 -> STABLE_y. level=y and pending slot written on the same edge.
  - WAIT_y otherwise -> count+1.
  - Counter width = $clog2(DEBOUNCE_CYCLES+1). No wrap is possible.
- Latency: pin change sampled at edge 0 -> level updates at edge SYNC_STAGES+DEBOUNCE_CYCLES -> evt_valid high after the next edge.
- Pending slot per channel holds {valid, rise}.
  - Write while valid and not granted this cycle: overwrite with the newest event and set overflow[ch].
  - Write in the same cycle the slot is granted: no overflow; the slot holds the new event.
- Output register loads when !evt_valid || evt_ready. It takes the first valid slot searching from pointer, pointer+1, ... modulo NUM_CH. The granted slot is cleared and pointer := granted+1 (wraps to 0).
- If the register can load and no slot is valid: evt_valid=0.
- evt_channel and evt_rise are held stable while evt_valid && !evt_ready.
- Back-to-back throughput: one event per cycle when evt_ready held high.

Decomposition:
- Package p09_debounce_pkg:
  - state enum (STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW, 2 bits)
  - event struct {channel, rise}
  - width helper function for channel index and counter.
- Sub-module p09_debounce_channel: sync chain, FSM, counter, level. Outputs a one-cycle event strobe plus polarity.
- The top module holds the pending slots, round-robin arbiter, output register and overflow flags.

Test Plan:
- NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4; in[1] 0->1 sampled at edge 0, held -> level[1]=1 after edge 6; evt_valid=1, evt_channel=1, evt_rise=1 after edge 7; accepted with evt_ready=1; evt_valid=0 next cycle.
- Glitch: in[0] high for 3 cycles then low -> level stays 0, no event, overflow=0; 4-cycle pulse (held high) -> rise event.
- in[0], in[2], in[3] rise on the same cycle with evt_ready=1 -> events on consecutive cycles with channels 0, 2, 3. Then a second round starting at ch3 with in[3], in[0] simultaneous -> order 0, 3 (pointer=0 after 3 granted).
- evt_ready=0 while ch1 rises then falls (8+ cycles apart) -> presented event stays {1, rise}; fall lands in the slot; an extra rise overwrites it -> overflow[1]=1. overflow_clr[1] pulse -> 0. Clear coincident with a set -> 0.
- Reset asserted for 1 cycle while evt_valid=1 and slots pending -> next cycle evt_valid=0, level=0, no stale events; inputs held high -> rise events after full latency.
- DEBOUNCE_CYCLES=1, NUM_CH=1: single-cycle sync_out change in the middle of a WAIT state returns to STABLE. evt_channel width 1 and always 0.
